// File: rtl/cordic_sweep_nco.sv
// Phase-sweep generator for a 16-stage CORDIC rotator: issues a constant or chirped
// phase sequence and tracks the rotator's fixed latency to flag valid/last outputs.
module cordic_sweep_nco #(
    parameter int                     WD  = 32,
    parameter int                     LAT = 17,
    parameter logic signed [WD-1:0]   AMP = 32'sh26DD3B6A
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [31:0]   cfg_phase0,
    input  logic [31:0]   cfg_fcw,
    input  logic [31:0]   cfg_step,
    input  logic [15:0]   cfg_len,
    input  logic          ce,
    input  logic          abort,
    output logic [31:0]   phi,
    output logic [WD-1:0] x0,
    output logic [WD-1:0] y0,
    output logic          in_valid,
    output logic          out_valid,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          aborted
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [31:0]    phase_q, phase_d;
    logic [31:0]    fcw_q, fcw_d;
    logic [31:0]    step_q, step_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [31:0]    phi_q, phi_d;
    logic           in_valid_q, in_valid_d;
    logic           last_q, last_d;
    logic           aborted_q, aborted_d;
    logic [LAT-1:0] dly_v_q, dly_l_q;
    logic           drain_empty;

    // Nothing still valid after this cycle: the tap may hold the final sample now.
    assign drain_empty = !in_valid_q && (dly_v_q[LAT-2:0] == '0);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        fcw_d      = fcw_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        phi_d      = phi_q;
        in_valid_d = 1'b0;
        last_d     = 1'b0;
        aborted_d  = aborted_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    phase_d   = cfg_phase0;
                    fcw_d     = cfg_fcw;
                    step_d    = cfg_step;
                    cnt_d     = cfg_len;
                    aborted_d = 1'b0;
                    // An empty sweep passes through DRAIN so done lands two cycles after accept.
                    state_d   = (cfg_len == 16'd0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DRAIN;
                end else if (ce) begin
                    phi_d      = phase_q;
                    in_valid_d = 1'b1;
                    last_d     = (cnt_q == 16'd1);
                    phase_d    = phase_q + fcw_q;
                    fcw_d      = fcw_q + step_q;
                    cnt_d      = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_empty) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            fcw_q      <= '0;
            step_q     <= '0;
            cnt_q      <= '0;
            phi_q      <= '0;
            in_valid_q <= 1'b0;
            last_q     <= 1'b0;
            aborted_q  <= 1'b0;
            dly_v_q    <= '0;
            dly_l_q    <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            fcw_q      <= fcw_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            phi_q      <= phi_d;
            in_valid_q <= in_valid_d;
            last_q     <= last_d;
            aborted_q  <= aborted_d;
            dly_v_q    <= {dly_v_q[LAT-2:0], in_valid_q};
            dly_l_q    <= {dly_l_q[LAT-2:0], last_q};
        end
    end

    assign cfg_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign aborted   = done && aborted_q;
    assign phi       = phi_q;
    assign in_valid  = in_valid_q;
    assign out_valid = dly_v_q[LAT-1];
    assign out_last  = dly_l_q[LAT-1];
    assign x0        = AMP;
    assign y0        = '0;

endmodule

// File: tb/tb_cordic_sweep_nco.sv
// Self-checking bench for cordic_sweep_nco: directed and random sweeps against a
// closed-form phase model and cycle-level timing rules.
module tb_cordic_sweep_nco;

    localparam int          LAT = 17;
    localparam int          WD  = 32;
    localparam logic [31:0] AMP = 32'h26DD3B6A;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [31:0]   cfg_phase0;
    logic [31:0]   cfg_fcw;
    logic [31:0]   cfg_step;
    logic [15:0]   cfg_len;
    logic          ce;
    logic          abort;
    logic [31:0]   phi;
    logic [WD-1:0] x0;
    logic [WD-1:0] y0;
    logic          in_valid;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          aborted;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [31:0] hold_phi;

    cordic_sweep_nco #(.WD(WD), .LAT(LAT), .AMP(32'sh26DD3B6A)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_phase0(cfg_phase0), .cfg_fcw(cfg_fcw), .cfg_step(cfg_step), .cfg_len(cfg_len),
        .ce(ce), .abort(abort),
        .phi(phi), .x0(x0), .y0(y0),
        .in_valid(in_valid), .out_valid(out_valid), .out_last(out_last),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Closed form: phase0 + n*fcw + step*n(n-1)/2, all modulo 2^32.
    function automatic logic [31:0] phi_ref(input logic [31:0] p0, input logic [31:0] f,
                                            input logic [31:0] s, input int n);
        logic [31:0] nn;
        logic [63:0] tr;
        nn = 32'(n);
        tr = (64'(nn) * 64'(nn - 32'd1)) / 64'd2;
        return p0 + f * nn + s * tr[31:0];
    endfunction

    task automatic check_all(input logic [31:0] e_phi, input logic e_inv, input logic e_ov,
                             input logic e_ol, input logic e_busy, input logic e_done,
                             input logic e_ab);
        chk("phi",       phi,              e_phi);
        chk("in_valid",  32'(in_valid),    32'(e_inv));
        chk("out_valid", 32'(out_valid),   32'(e_ov));
        chk("out_last",  32'(out_last),    32'(e_ol));
        chk("busy",      32'(busy),        32'(e_busy));
        chk("cfg_ready", 32'(cfg_ready),   32'(!e_busy));
        chk("done",      32'(done),        32'(e_done));
        chk("aborted",   32'(aborted),     32'(e_ab));
        chk("x0",        x0,               AMP);
        chk("y0",        y0,               32'h0);
    endtask

    // mode: 0 = ce always high, 1 = ce toggles 1,0,1,..., 2 = random ce.
    // abort_after / rst_after: sample count at which abort / rst is raised (-1 = never).
    task automatic run_sweep(input logic [31:0] p0, input logic [31:0] f, input logic [31:0] s,
                             input int len, input int mode, input int abort_after,
                             input int rst_after);
        int  a, issued, e, done_cyc, rst_cyc, bound, t;
        bit  ended, abf, full, cen, e_inv, e_ov, e_ol, e_busy, e_done;
        int  pres[$];
        a = cyc; issued = 0; e = 0; done_cyc = 0; rst_cyc = -1;
        ended = 0; abf = 0; full = 0;
        bound = a + (len + 2) * 8 + 3 * LAT + 20;
        check_all(hold_phi, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cfg_valid = 1'b1; cfg_phase0 = p0; cfg_fcw = f; cfg_step = s; cfg_len = 16'(len);
        ce = 1'($urandom); abort = 1'b0;
        if (len == 0) begin
            ended = 1; e = a; done_cyc = a + 2;
        end
        while (1) begin
            @(posedge clk); #1; cyc++; t = cyc;
            if (rst_cyc >= 0) begin
                check_all(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                rst = 1'b0; cfg_valid = 1'b0; abort = 1'b0; ce = 1'($urandom);
                if (t >= rst_cyc + LAT + 3) break;
                continue;
            end
            e_inv = (pres.size() > 0) && (pres[$] == t);
            if (e_inv) hold_phi = phi_ref(p0, f, s, pres.size() - 1);
            e_ov = 0;
            foreach (pres[i]) if (pres[i] + LAT == t) e_ov = 1;
            e_ol   = e_ov && full && (pres[$] + LAT == t);
            e_busy = !ended || (t <= done_cyc);
            e_done = ended && (t == done_cyc);
            check_all(hold_phi, e_inv, e_ov, e_ol, e_busy, e_done, e_done && abf);
            if (ended && t >= done_cyc + 1) begin
                cfg_valid = 1'b0; ce = 1'b0; abort = 1'b0;
                break;
            end
            if (t > bound) begin
                chk("timeout", 32'd0, 32'd1);
                rst = 1'b1; cfg_valid = 1'b0;
                @(posedge clk); #1; cyc++;
                rst = 1'b0; hold_phi = '0;
                return;
            end
            cfg_valid = 1'($urandom); cfg_phase0 = $urandom; cfg_fcw = $urandom;
            cfg_step = $urandom; cfg_len = 16'($urandom_range(0, 9));
            if (!ended) begin
                case (mode)
                    0:       cen = 1;
                    1:       cen = ((t - a - 1) % 2) == 0;
                    default: cen = ($urandom % 4) != 0;
                endcase
                if (rst_after >= 0 && issued == rst_after) begin
                    rst = 1'b1; ce = 1'b1; abort = 1'b0; cfg_valid = 1'b0;
                    rst_cyc = t; pres.delete(); hold_phi = '0;
                    continue;
                end else if (abort_after >= 0 && issued == abort_after) begin
                    abort = 1'b1; ce = 1'b1; abf = 1; ended = 1; e = t;
                end else begin
                    abort = 1'b0; ce = cen;
                    if (cen) begin
                        pres.push_back(t + 1);
                        issued++;
                        if (issued == len) begin ended = 1; full = 1; e = t; end
                    end
                end
                if (ended) begin
                    done_cyc = e + 2;
                    if (pres.size() > 0 && pres[$] + LAT + 1 > done_cyc) done_cyc = pres[$] + LAT + 1;
                end
            end else begin
                ce = 1'($urandom); abort = 1'($urandom);
            end
        end
    endtask

    initial begin
        int len;
        rst = 1'b1; cfg_valid = 1'b0; cfg_phase0 = '0; cfg_fcw = '0; cfg_step = '0;
        cfg_len = '0; ce = 1'b0; abort = 1'b0; hold_phi = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1; cyc++;

        run_sweep(32'h0,        32'h10000000, 32'h0,        4,   0, -1, -1);
        run_sweep(32'h0,        32'h0,        32'h01000000, 4,   0, -1, -1);
        run_sweep(32'hF0000000, 32'h20000000, 32'h0,        3,   1, -1, -1);
        run_sweep(32'h12345678, 32'h00000100, 32'h0,        0,   0, -1, -1);
        run_sweep(32'h40000000, 32'h01000000, 32'h00000010, 100, 0,  5, -1);
        run_sweep(32'h0,        32'h00100000, 32'h0,        1,   0, -1, -1);
        run_sweep(32'h0,        32'h00100000, 32'h0,        20,  0,  0, -1);
        run_sweep(32'h11111111, 32'h02000000, 32'h00010000, 50,  0, -1, 10);
        run_sweep(32'hC0000000, 32'h08000000, 32'hFFF00000, 6,   0, -1, -1);
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(1, 40);
            run_sweep($urandom, $urandom, $urandom, len, 2,
                      (($urandom % 3) == 0) ? int'($urandom_range(0, len - 1)) : -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
